// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Two-byte instruction fetch from byte-wide memory into a 16-bit IR
// Revision : 1.0
// ============================================================================
module instr_fetch_unit #(
    parameter int ADDRESS_WIDTH = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int INSTR_WIDTH   = 2 * DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] pc_i,
    input  logic                     fetch_start_i,
    input  logic                     flush_i,
    output logic                     mem_rd_en_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
    input  logic                     mem_rvalid_i,
    output logic [INSTR_WIDTH-1:0]   instr_o,
    output logic                     instr_valid_o,
    output logic [ADDRESS_WIDTH-1:0] fetch_pc_o,
    output logic                     busy_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ_LO  = 3'd1;
    localparam logic [2:0] S_WAIT_LO = 3'd2;
    localparam logic [2:0] S_REQ_HI  = 3'd3;
    localparam logic [2:0] S_WAIT_HI = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_DRAIN   = 3'd6;

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = 1;

    logic [2:0]               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] base_q,  base_d;
    logic [DATA_WIDTH-1:0]    lo_q,    lo_d;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic [ADDRESS_WIDTH-1:0] fpc_q,   fpc_d;
    logic                     rd_en_q, rd_en_d;
    logic [ADDRESS_WIDTH-1:0] addr_q,  addr_d;
    logic                     valid_q, valid_d;
    logic                     busy_q,  busy_d;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        lo_d    = lo_q;
        instr_d = instr_q;
        fpc_d   = fpc_q;

        case (state_q)
            S_IDLE: begin
                if (fetch_start_i && !flush_i) begin
                    base_d  = pc_i;
                    state_d = S_REQ_LO;
                end
            end
            S_REQ_LO: begin
                state_d = flush_i ? S_IDLE : S_WAIT_LO;
            end
            S_WAIT_LO: begin
                // A flush with no data yet still owes us one response: drain it.
                if (flush_i) begin
                    state_d = mem_rvalid_i ? S_IDLE : S_DRAIN;
                end else if (mem_rvalid_i) begin
                    lo_d    = mem_rdata_i;
                    state_d = S_REQ_HI;
                end
            end
            S_REQ_HI: begin
                state_d = flush_i ? S_IDLE : S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (flush_i) begin
                    state_d = mem_rvalid_i ? S_IDLE : S_DRAIN;
                end else if (mem_rvalid_i) begin
                    instr_d = {mem_rdata_i, lo_q};
                    fpc_d   = base_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (mem_rvalid_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_en_d = (state_d == S_REQ_LO) || (state_d == S_REQ_HI);
        addr_d  = addr_q;
        if (state_d == S_REQ_LO) begin
            addr_d = base_d;
        end else if (state_d == S_REQ_HI) begin
            addr_d = base_q + ADDR_ONE;
        end
        valid_d = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            lo_q    <= '0;
            instr_q <= '0;
            fpc_q   <= '0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            lo_q    <= lo_d;
            instr_q <= instr_d;
            fpc_q   <= fpc_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Flush acts within its own cycle: it kills a pending strobe or valid pulse.
    assign mem_rd_en_o   = rd_en_q & ~flush_i;
    assign instr_valid_o = valid_q & ~flush_i;
    assign mem_addr_o    = addr_q;
    assign instr_o       = instr_q;
    assign fetch_pc_o    = fpc_q;
    assign busy_o        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// Testbench for instr_fetch_unit: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_instr_fetch_unit;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int IW = 16;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_DONE  = 2;
    localparam int M_DRAIN = 3;

    logic          clk           = 1'b0;
    logic          rst_n         = 1'b0;
    logic [AW-1:0] pc_i          = '0;
    logic          fetch_start_i = 1'b0;
    logic          flush_i       = 1'b0;
    logic          mem_rd_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_rdata_i   = '0;
    logic          mem_rvalid_i  = 1'b0;
    logic [IW-1:0] instr_o;
    logic          instr_valid_o;
    logic [AW-1:0] fetch_pc_o;
    logic          busy_o;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .INSTR_WIDTH  (IW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_i         (pc_i),
        .fetch_start_i(fetch_start_i),
        .flush_i      (flush_i),
        .mem_rd_en_o  (mem_rd_en_o),
        .mem_addr_o   (mem_addr_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_rvalid_i (mem_rvalid_i),
        .instr_o      (instr_o),
        .instr_valid_o(instr_valid_o),
        .fetch_pc_o   (fetch_pc_o),
        .busy_o       (busy_o)
    );

    logic [DW-1:0] mem [0:7];
    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // transaction-level model: which byte we are on and whether its read went out
    int            m_mode;
    int            m_byte;
    bit            m_issued;
    logic [AW-1:0] m_base;
    logic [DW-1:0] m_lo;
    logic [IW-1:0] m_instr;
    logic [AW-1:0] m_fpc;

    int            mem_cnt = 0;
    logic [AW-1:0] mem_pend = '0;
    int            lat = 1;
    int            valid_pulses = 0;
    int            strobes = 0;
    bit            saw_valid = 1'b0;
    logic [AW-1:0] addr_log [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_byte   = 0;
        m_issued = 1'b0;
        m_base   = '0;
        m_lo     = '0;
        m_instr  = '0;
        m_fpc    = '0;
    endtask

    task automatic compare();
        logic [AW-1:0] ea;
        bit            exp_rd;
        ea     = m_base + AW'(m_byte);
        exp_rd = (m_mode == M_FETCH) && !m_issued && !flush_i;
        chk("busy", 32'(busy_o), 32'(m_mode != M_IDLE));
        chk("mem_rd_en", 32'(mem_rd_en_o), 32'(exp_rd));
        if (exp_rd) chk("mem_addr", 32'(mem_addr_o), 32'(ea));
        chk("instr_valid", 32'(instr_valid_o), 32'((m_mode == M_DONE) && !flush_i));
        chk("instr", 32'(instr_o), 32'(m_instr));
        chk("fetch_pc", 32'(fetch_pc_o), 32'(m_fpc));
    endtask

    task automatic model_step();
        logic [AW-1:0] hi_a;
        hi_a = m_base + AW'(1);
        case (m_mode)
            M_IDLE: begin
                if (fetch_start_i && !flush_i) begin
                    m_base   = pc_i;
                    m_byte   = 0;
                    m_issued = 1'b0;
                    m_mode   = M_FETCH;
                end
            end
            M_FETCH: begin
                if (!m_issued) begin
                    if (flush_i) m_mode = M_IDLE;
                    else         m_issued = 1'b1;
                end else if (flush_i) begin
                    m_mode = mem_rvalid_i ? M_IDLE : M_DRAIN;
                end else if (mem_rvalid_i) begin
                    if (m_byte == 0) begin
                        m_lo     = mem[m_base];
                        m_byte   = 1;
                        m_issued = 1'b0;
                    end else begin
                        m_instr = {mem[hi_a], m_lo};
                        m_fpc   = m_base;
                        m_mode  = M_DONE;
                    end
                end
            end
            M_DONE:  m_mode = M_IDLE;
            default: if (mem_rvalid_i) m_mode = M_IDLE;
        endcase
    endtask

    task automatic cycle(input bit fs, input bit fl, input logic [AW-1:0] p);
        @(negedge clk);
        cyc++;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = DW'($urandom);
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem[mem_pend];
            end
        end
        fetch_start_i = fs;
        flush_i       = fl;
        pc_i          = p;
        #1;
        compare();
        saw_valid = (instr_valid_o === 1'b1);
        if (saw_valid) valid_pulses++;
        if (mem_rd_en_o === 1'b1) begin
            strobes++;
            addr_log.push_back(mem_addr_o);
            chk("one_outstanding", 32'(mem_cnt), 32'd0);
            mem_cnt  = (lat > 0) ? lat : int'($urandom_range(1, 4));
            mem_pend = mem_addr_o;
        end
        model_step();
    endtask

    task automatic do_fetch(input logic [AW-1:0] p, input int l, output int dly);
        int start;
        lat = l;
        cycle(1'b1, 1'b0, p);
        start     = cyc;
        saw_valid = 1'b0;
        for (int i = 0; i < 40 && !saw_valid; i++) cycle(1'b0, 1'b0, p);
        dly = saw_valid ? (cyc - start) : -1;
    endtask

    initial begin
        int d;
        int s0;
        int v0;
        int start;

        mem[0] = 8'hAB; mem[1] = 8'h11; mem[2] = 8'h34; mem[3] = 8'h12;
        mem[4] = 8'h78; mem[5] = 8'h56; mem[6] = 8'hBC; mem[7] = 8'hCD;
        model_reset();

        repeat (2) @(negedge clk);
        #1;
        chk("rst_instr", 32'(instr_o), 32'h0);
        chk("rst_valid", 32'(instr_valid_o), 32'h0);
        chk("rst_fetch_pc", 32'(fetch_pc_o), 32'h0);
        chk("rst_rd_en", 32'(mem_rd_en_o), 32'h0);
        chk("rst_addr", 32'(mem_addr_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        rst_n = 1'b1;

        // basic fetch, latency 1
        addr_log.delete();
        do_fetch(3'd2, 1, d);
        chk("t1_latency", 32'(d), 32'd5);
        chk("t1_instr", 32'(instr_o), 32'h1234);
        chk("t1_model_pin", 32'(m_instr), 32'h1234);
        chk("t1_fetch_pc", 32'(fetch_pc_o), 32'd2);
        chk("t1_nreads", 32'(addr_log.size()), 32'd2);
        if (addr_log.size() == 2) begin
            chk("t1_addr_lo", 32'(addr_log[0]), 32'd2);
            chk("t1_addr_hi", 32'(addr_log[1]), 32'd3);
        end
        cycle(1'b0, 1'b0, 3'd0);
        chk("t1_valid_one_cycle", 32'(instr_valid_o), 32'h0);
        chk("t1_busy_after", 32'(busy_o), 32'h0);

        // wrap-around
        addr_log.delete();
        do_fetch(3'd7, 1, d);
        chk("t2_instr", 32'(instr_o), 32'hABCD);
        if (addr_log.size() == 2) begin
            chk("t2_addr_lo", 32'(addr_log[0]), 32'd7);
            chk("t2_addr_hi", 32'(addr_log[1]), 32'd0);
        end else chk("t2_nreads", 32'(addr_log.size()), 32'd2);

        // latency 3 with an ignored second request
        lat = 3;
        s0  = strobes;
        cycle(1'b1, 1'b0, 3'd5);
        start     = cyc;
        saw_valid = 1'b0;
        for (int i = 0; i < 40 && !saw_valid; i++) cycle(i == 1, 1'b0, 3'd1);
        chk("t3_latency", 32'(saw_valid ? cyc - start : -1), 32'd9);
        chk("t3_instr", 32'(instr_o), 32'hBC56);
        repeat (8) cycle(1'b0, 1'b0, 3'd0);
        chk("t3_strobes", 32'(strobes - s0), 32'd2);
        chk("t3_idle", 32'(busy_o), 32'h0);

        // flush in WAIT_LO, late data drained
        do_fetch(3'd2, 1, d);
        chk("t4_pre_instr", 32'(instr_o), 32'h1234);
        lat = 3;
        v0  = valid_pulses;
        cycle(1'b1, 1'b0, 3'd2);
        cycle(1'b0, 1'b0, 3'd2);
        cycle(1'b0, 1'b1, 3'd2);
        cycle(1'b0, 1'b0, 3'd2);
        chk("t4_drain_busy", 32'(busy_o), 32'h1);
        repeat (4) cycle(1'b0, 1'b0, 3'd2);
        chk("t4_instr_kept", 32'(instr_o), 32'h1234);
        chk("t4_no_valid", 32'(valid_pulses - v0), 32'd0);
        chk("t4_drained", 32'(mem_cnt), 32'd0);
        chk("t4_idle", 32'(busy_o), 32'h0);
        do_fetch(3'd4, 1, d);
        chk("t4_next_instr", 32'(instr_o), 32'h5678);

        // flush with fetch_start in IDLE; flush in DONE
        s0 = strobes;
        cycle(1'b1, 1'b1, 3'd3);
        repeat (3) cycle(1'b0, 1'b0, 3'd3);
        chk("t5_no_strobe", 32'(strobes - s0), 32'd0);
        chk("t5_no_busy", 32'(busy_o), 32'h0);
        lat = 1;
        v0  = valid_pulses;
        cycle(1'b1, 1'b0, 3'd2);
        repeat (4) cycle(1'b0, 1'b0, 3'd2);
        cycle(1'b0, 1'b1, 3'd2);
        chk("t5_done_valid_suppressed", 32'(valid_pulses - v0), 32'd0);
        chk("t5_done_instr", 32'(instr_o), 32'h1234);
        chk("t5_done_fetch_pc", 32'(fetch_pc_o), 32'd2);

        // asynchronous reset in WAIT_HI
        lat = 3;
        cycle(1'b1, 1'b0, 3'd4);
        repeat (6) cycle(1'b0, 1'b0, 3'd4);
        chk("t6_busy_before", 32'(busy_o), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_instr", 32'(instr_o), 32'h0);
        chk("t6_rst_busy", 32'(busy_o), 32'h0);
        chk("t6_rst_rd_en", 32'(mem_rd_en_o), 32'h0);
        chk("t6_rst_fetch_pc", 32'(fetch_pc_o), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        v0 = valid_pulses;
        repeat (5) cycle(1'b0, 1'b0, 3'd0);
        chk("t6_late_ignored_instr", 32'(instr_o), 32'h0);
        chk("t6_late_ignored_busy", 32'(busy_o), 32'h0);
        chk("t6_late_no_valid", 32'(valid_pulses - v0), 32'd0);

        // randomized traffic
        for (int i = 0; i < 8; i++) mem[i] = DW'($urandom);
        lat = 0;
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 8, AW'($urandom));
        end
        repeat (20) cycle(1'b0, 1'b0, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage between the byte-wide instruction memory and the decoder. Produces the 16-bit instruction register contents.
- On a fetch request from the control FSM, captures the PC and issues two byte reads to instruction memory: low byte at pc, high byte at pc+1.
- Assembles {high, low} into the instruction register, holds it stable for the decoder, and pulses instr_valid.
- Supports flush (jump or branch redirect) with draining of an outstanding read.

Parameters:
ADDRESS_WIDTH, 3, instruction memory byte-address width (8 bytes)
DATA_WIDTH, 8, memory byte width
INSTR_WIDTH, 16, instruction width; fixed at 2*DATA_WIDTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
pc  input  ADDRESS_WIDTH  current program counter, byte address of the instruction's low byte
fetch_start  input  1  request a fetch; sampled only in IDLE
flush  input  1  abort the current fetch (redirect)
mem_rd_en  output  1  one-cycle read strobe to instruction memory
mem_addr  output  ADDRESS_WIDTH  read byte address; valid while mem_rd_en=1
mem_rdata  input  DATA_WIDTH  read data; valid when mem_rvalid=1
mem_rvalid  input  1  read data valid; arrives 1 or more cycles after mem_rd_en
instr  output  INSTR_WIDTH  instruction register, to decoder; holds until the next completed fetch
instr_valid  output  1  one-cycle pulse when instr is updated
fetch_pc  output  ADDRESS_WIDTH  pc of the instruction currently held in instr
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - instr=0, instr_valid=0, fetch_pc=0, mem_rd_en=0, mem_addr=0, busy=0.
  - Internal base_addr=0, lo_byte=0.
  - Reset mid-fetch clears all of the above immediately; no partial instr update.
- All outputs are registered.
- States: IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, DONE, DRAIN.
- IDLE: if fetch_start=1 and flush=0, base_addr<=pc and go to REQ_LO. Otherwise stay.
- REQ_LO: mem_rd_en=1 and mem_addr=base_addr for exactly one cycle. Go to WAIT_LO.
- WAIT_LO: on mem_rvalid=1, lo_byte<=mem_rdata and go to REQ_HI. Otherwise wait, with no timeout.
- REQ_HI: mem_rd_en=1 and mem_addr=(base_addr+1) mod 2^ADDRESS_WIDTH. pc=7 gives high address 0 (wrap). Go to WAIT_HI.
- WAIT_HI: on mem_rvalid=1, instr<={mem_rdata, lo_byte}, fetch_pc<=base_addr, and go to DONE.
- DONE: instr_valid=1 for this cycle only. Go to IDLE.
  - fetch_start is accepted again on the cycle after DONE.
  - Back-to-back fetches therefore take 6 cycles each at minimum.
- Minimum latency: fetch_start sampled in cycle 0, REQ_LO in cycle 1, rvalid in cycle 2, REQ_HI in cycle 3, rvalid in cycle 4, instr and instr_valid visible in cycle 5.
- mem_rvalid is ignored in IDLE, REQ_LO, REQ_HI and DONE.
- fetch_start is ignored in every state except IDLE; there is no queuing.
- Flush, which has priority over every other event:
  - IDLE: flush cancels a simultaneous fetch_start.
  - REQ_LO or REQ_HI: the strobe is not issued; go to IDLE.
  - WAIT_LO or WAIT_HI with mem_rvalid=0: go to DRAIN.
  - WAIT_LO or WAIT_HI with mem_rvalid=1 in the same cycle: data is discarded; go to IDLE.
  - DONE: instr_valid is suppressed that cycle, instr keeps its new value, and fetch_pc is updated.
  - On flush, instr and fetch_pc otherwise keep their old values.
- DRAIN: wait for mem_rvalid, discard the data, then go to IDLE. flush and fetch_start are ignored in DRAIN.
- At most one memory read is outstanding at any time.
- instr is never partially updated; it changes only on the WAIT_HI-to-DONE edge.

Test Plan:
1. Basic fetch: mem[2]=0x34, mem[3]=0x12, memory latency 1; rst released; pc=2 with a fetch_start pulse -> reads at addresses 2 then 3; instr=0x1234, fetch_pc=2, instr_valid high for exactly 1 cycle, 5 cycles after fetch_start; busy low afterwards.
2. Wrap-around: pc=7, mem[7]=0xCD, mem[0]=0xAB -> mem_addr sequence 7, 0; instr=0xABCD.
3. Variable latency plus ignored request: rvalid arrives 3 cycles after each strobe; a second fetch_start is asserted while busy -> exactly 2 strobes issued; instr correct after 9 cycles; no second fetch starts.
4. Flush in WAIT_LO with data 2 cycles late: previous instr=0x1234 -> DRAIN consumes the late rvalid; instr stays 0x1234; no instr_valid. A subsequent fetch at pc=4 (mem 0x78, 0x56) yields 0x5678.
5. Flush and fetch_start in the same IDLE cycle -> no mem_rd_en, busy stays 0. Flush in DONE -> instr updated, instr_valid stays 0.
6. Asynchronous reset asserted in WAIT_HI between clock edges -> instr=0, busy=0, mem_rd_en=0 immediately, without waiting for a clock edge. After release, a late mem_rvalid is ignored.
